// File: rtl/seq_match_counter.sv
// seq_match_counter: counts match pulses (z) from an upstream sequence
// detector over fixed windows of WINDOW_LEN cycles and hands each window
// result to a consumer through a valid/ready register with a sticky
// overrun flag for dropped results.
// Optional build macro SEQ_MATCH_CNT_SAT_EN: when defined the per-window
// accumulator saturates at all-ones instead of wrapping.
module seq_match_counter #(
  parameter int WINDOW_LEN = 16,
  parameter int CNT_W      = 8
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             z,
  input  logic             start,
  input  logic             stop,
  output logic [CNT_W-1:0] count_out,
  output logic             count_valid,
  input  logic             count_ready,
  output logic             overrun,
  output logic             busy
);

  // Window counter is ceil(log2(WINDOW_LEN)) bits and wraps at WINDOW_LEN-1.
  localparam int WIN_W = (WINDOW_LEN > 1) ? $clog2(WINDOW_LEN) : 1;
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW_LEN - 1);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    COUNT = 1'b1
  } state_t;

  state_t           state_r;
  logic [CNT_W-1:0] acc_r;
  logic [WIN_W-1:0] win_r;

  logic [CNT_W-1:0] acc_inc_s;
  logic             win_last_s;
  logic             win_end_s;
  logic             accept_s;
  logic             load_s;
  logic             drop_s;

  // Accumulator value including this cycle's match pulse.
  always_comb begin
    acc_inc_s = acc_r;
`ifdef SEQ_MATCH_CNT_SAT_EN
    if (z && (acc_r != {CNT_W{1'b1}})) begin
      acc_inc_s = acc_r + CNT_W'(1'b1);
    end else begin
      acc_inc_s = acc_r;
    end
`else
    if (z) begin
      acc_inc_s = acc_r + CNT_W'(1'b1);
    end else begin
      acc_inc_s = acc_r;
    end
`endif
  end

  // Window completion and result hand-off decisions for this cycle.
  always_comb begin
    win_last_s = (win_r == WIN_LAST);
    // A stop on the last window cycle aborts the window, so no result.
    win_end_s  = (state_r == COUNT) && !stop && win_last_s;
    accept_s   = count_valid && count_ready;
    // The output slot is free if empty or being drained this same cycle.
    load_s     = win_end_s && (!count_valid || count_ready);
    drop_s     = win_end_s && count_valid && !count_ready;
  end

  // Control FSM: window counter, accumulator and busy flag.
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state_r <= IDLE;
      acc_r   <= {CNT_W{1'b0}};
      win_r   <= {WIN_W{1'b0}};
      busy    <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          // z is ignored while idle; each run starts from a clean window.
          acc_r <= {CNT_W{1'b0}};
          win_r <= {WIN_W{1'b0}};
          if (start && !stop) begin
            state_r <= COUNT;
            busy    <= 1'b1;
          end else begin
            state_r <= IDLE;
            busy    <= 1'b0;
          end
        end
        COUNT: begin
          if (stop) begin
            // Abort: partial window is discarded, pending output kept.
            state_r <= IDLE;
            busy    <= 1'b0;
            acc_r   <= {CNT_W{1'b0}};
            win_r   <= {WIN_W{1'b0}};
          end else if (win_last_s) begin
            // Back-to-back windows: restart with no idle gap.
            state_r <= COUNT;
            busy    <= 1'b1;
            acc_r   <= {CNT_W{1'b0}};
            win_r   <= {WIN_W{1'b0}};
          end else begin
            state_r <= COUNT;
            busy    <= 1'b1;
            acc_r   <= acc_inc_s;
            win_r   <= win_r + WIN_W'(1'b1);
          end
        end
        default: begin
          state_r <= IDLE;
          busy    <= 1'b0;
          acc_r   <= {CNT_W{1'b0}};
          win_r   <= {WIN_W{1'b0}};
        end
      endcase
    end
  end

  // Result register with valid/ready hand-off and sticky overrun flag.
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      count_out   <= {CNT_W{1'b0}};
      count_valid <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      if (load_s) begin
        count_out   <= acc_inc_s;
        count_valid <= 1'b1;
      end else if (accept_s) begin
        count_out   <= count_out;
        count_valid <= 1'b0;
      end else begin
        // Held stable while the consumer stalls.
        count_out   <= count_out;
        count_valid <= count_valid;
      end
      if (drop_s) begin
        overrun <= 1'b1;
      end else begin
        overrun <= overrun;
      end
    end
  end

endmodule

// File: tb/tb_seq_match_counter.sv
// Directed self-checking bench for seq_match_counter. u_dut uses the
// default 16-cycle window; u_dut2 (CNT_W=2, WINDOW_LEN=32) exercises the
// accumulator overflow behaviour selected by SEQ_MATCH_CNT_SAT_EN.
module tb_seq_match_counter;

  logic       Clock;
  logic       Reset;
  logic       z, start, stop, count_ready;
  logic [7:0] count_out;
  logic       count_valid, overrun, busy;

  logic       z2, start2, stop2, count_ready2;
  logic [1:0] count_out2;
  logic       count_valid2, overrun2, busy2;

  int errors = 0;
  int checks = 0;
  logic seen_valid, seen_busy;

`ifdef SEQ_MATCH_CNT_SAT_EN
  localparam logic [1:0] EXP_OVF = 2'd3;
`else
  localparam logic [1:0] EXP_OVF = 2'd1;
`endif

  seq_match_counter #(.WINDOW_LEN(16), .CNT_W(8)) u_dut (
    .Clock(Clock), .Reset(Reset), .z(z), .start(start), .stop(stop),
    .count_out(count_out), .count_valid(count_valid),
    .count_ready(count_ready), .overrun(overrun), .busy(busy)
  );

  seq_match_counter #(.WINDOW_LEN(32), .CNT_W(2)) u_dut2 (
    .Clock(Clock), .Reset(Reset), .z(z2), .start(start2), .stop(stop2),
    .count_out(count_out2), .count_valid(count_valid2),
    .count_ready(count_ready2), .overrun(overrun2), .busy(busy2)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    Reset = 1'b0; z = 1'b1; start = 1'b1; stop = 1'b0; count_ready = 1'b0;
    z2 = 1'b1; start2 = 1'b1; stop2 = 1'b0; count_ready2 = 1'b0;

    // Reset held two cycles while start and z are asserted.
    tick(); tick();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_valid", 32'(count_valid), 32'd0);
    check("rst_out", 32'(count_out), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    check("rst_busy2", 32'(busy2), 32'd0);
    check("rst_valid2", 32'(count_valid2), 32'd0);

    // Basic window: 3 matches, result on cycle 17, next on cycle 33.
    Reset = 1'b1; z = 1'b0; start = 1'b1; count_ready = 1'b1;
    z2 = 1'b0; start2 = 1'b0;
    tick();
    check("start_busy", 32'(busy), 32'd1);
    start = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      z = (k == 2 || k == 5 || k == 9);
      tick();
      if (k == 15) check("w1_not_early", 32'(count_valid), 32'd0);
    end
    check("w1_valid", 32'(count_valid), 32'd1);
    check("w1_out", 32'(count_out), 32'd3);
    for (int k = 17; k <= 32; k++) begin
      z = (k == 20);
      tick();
      if (k == 17) check("w1_one_pulse", 32'(count_valid), 32'd0);
    end
    check("w2_valid", 32'(count_valid), 32'd1);
    check("w2_out", 32'(count_out), 32'd1);
    z = 1'b0; stop = 1'b1;
    tick();
    stop = 1'b0;
    check("stop_busy", 32'(busy), 32'd0);
    check("stop_drain", 32'(count_valid), 32'd0);

    // Stalled consumer: 2 then 4 matches, second result dropped.
    count_ready = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 1; k <= 32; k++) begin
      z = (k == 1 || k == 16 || k == 17 || k == 18 || k == 25 || k == 32);
      tick();
      if (k == 16) begin
        check("ovr_w1_valid", 32'(count_valid), 32'd1);
        check("ovr_w1_out", 32'(count_out), 32'd2);
        check("ovr_w1_flag", 32'(overrun), 32'd0);
      end
      if (k == 24) check("ovr_stable", 32'(count_out), 32'd2);
    end
    check("ovr_w2_out", 32'(count_out), 32'd2);
    check("ovr_w2_valid", 32'(count_valid), 32'd1);
    check("ovr_w2_flag", 32'(overrun), 32'd1);
    z = 1'b0; count_ready = 1'b1; stop = 1'b1;
    tick();
    stop = 1'b0;
    check("ovr_xfer_valid", 32'(count_valid), 32'd0);
    check("ovr_sticky", 32'(overrun), 32'd1);
    check("ovr_busy", 32'(busy), 32'd0);

    // Abort on window cycle 9 with 2 matches, then a fresh window.
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      z = (k == 3 || k == 6);
      stop = (k == 9);
      tick();
    end
    stop = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    for (int i = 0; i < 10; i++) begin
      z = 1'b1;
      tick();
    end
    check("abort_no_result", 32'(count_valid), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);
    start = 1'b1; z = 1'b1;
    tick();
    start = 1'b0;
    check("restart_busy", 32'(busy), 32'd1);
    for (int k = 1; k <= 16; k++) begin
      z = (k == 16);
      start = (k == 5);
      tick();
      if (k == 15) check("restart_not_early", 32'(count_valid), 32'd0);
    end
    start = 1'b0; z = 1'b0;
    check("restart_valid", 32'(count_valid), 32'd1);
    check("restart_out", 32'(count_out), 32'd1);
    check("restart_sticky", 32'(overrun), 32'd1);
    stop = 1'b1;
    tick();
    stop = 1'b0;

    // start and stop together while idle: stays idle.
    start = 1'b1; stop = 1'b1;
    tick();
    start = 1'b0; stop = 1'b0;
    check("startstop_idle", 32'(busy), 32'd0);

    // Reset on window cycle 10 discards everything.
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      z = 1'b1;
      tick();
    end
    Reset = 1'b0; start = 1'b1; count_ready = 1'b0;
    tick();
    start = 1'b0;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_valid", 32'(count_valid), 32'd0);
    check("midrst_out", 32'(count_out), 32'd0);
    check("midrst_overrun", 32'(overrun), 32'd0);
    Reset = 1'b1; count_ready = 1'b1;
    seen_valid = 1'b0; seen_busy = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      z = i[0];
      tick();
      if (count_valid) seen_valid = 1'b1;
      if (busy) seen_busy = 1'b1;
    end
    z = 1'b0;
    check("postrst_no_valid", 32'(seen_valid), 32'd0);
    check("postrst_idle", 32'(seen_busy), 32'd0);

    // Narrow accumulator: 5 matches in a 32-cycle window on a 2-bit count.
    count_ready2 = 1'b1; start2 = 1'b1;
    tick();
    start2 = 1'b0;
    for (int k = 1; k <= 32; k++) begin
      z2 = (k <= 5);
      tick();
      if (k == 31) check("ovf_not_early", 32'(count_valid2), 32'd0);
    end
    z2 = 1'b0;
    check("ovf_valid", 32'(count_valid2), 32'd1);
    check("ovf_out", 32'(count_out2), 32'(EXP_OVF));
    check("ovf_no_overrun", 32'(overrun2), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
